// File: rtl/blctrl_i2c_master.sv
// Single-master I2C write engine: serialises one (address, speed byte) command per
// request as START, addr+W, ACK, data, ACK, STOP, with clock-stretch timeout.
module blctrl_i2c_master #(
   parameter int CLK_DIV       = 30,
   parameter int STRETCH_LIMIT = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       busy,
   output logic       done,
   output logic       nack,
   output logic       timeout,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       scl_o,
   output logic       sda_o,
   output logic       scl_t,
   output logic       sda_t
);
   localparam int SW = $clog2(STRETCH_LIMIT + 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_ACK, S_STOP, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [9:0]      timer;
   logic [1:0]      quarter;
   logic [2:0]      bit_cnt;
   logic            addr_phase;
   logic            ack_ok;
   logic [7:0]      shreg;
   logic [7:0]      data_q;
   logic [SW-1:0]   stretch_cnt;
   logic            nack_q;
   logic            timeout_q;
   logic            accept;
   logic            released;
   logic            stretched;
   logic            timeout_hit;
   logic            q_end;

   assign accept = cmd_valid && cmd_ready;
   // Quarters in which the master lets SCL float and a slave may stretch it
   assign released = (state == S_START && quarter == 2'd0) ||
                     ((state == S_BYTE || state == S_ACK) && quarter == 2'd2) ||
                     (state == S_STOP && quarter == 2'd1);
   assign stretched   = released && !scl_i;
   assign timeout_hit = stretched && (stretch_cnt == SW'(STRETCH_LIMIT - 1));
   assign q_end       = !stretched && (timer == 10'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_START;
         S_START: if (q_end && quarter == 2'd1) state_nxt = S_BYTE;
         S_BYTE:  if (q_end && quarter == 2'd3 && bit_cnt == 3'd0) state_nxt = S_ACK;
         S_ACK:   if (q_end && quarter == 2'd3)
                     state_nxt = (addr_phase && ack_ok) ? S_BYTE : S_STOP;
         S_STOP:  if (q_end && quarter == 2'd3) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (timeout_hit) state_nxt = S_DONE;
   end

   always_comb begin
      scl_t = 1'b1;
      sda_t = 1'b1;
      case (state)
         S_START: sda_t = (quarter == 2'd0);
         S_BYTE: begin
            scl_t = quarter[1];
            sda_t = shreg[7];
         end
         S_ACK:   scl_t = quarter[1];
         S_STOP: begin
            scl_t = (quarter != 2'd0);
            sda_t = quarter[1];
         end
         default: ;
      endcase
   end

   assign scl_o     = 1'b0;
   assign sda_o     = 1'b0;
   assign cmd_ready = (state == S_IDLE) && !rst;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign nack      = nack_q;
   assign timeout   = timeout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         timer       <= '0;
         quarter     <= '0;
         bit_cnt     <= '0;
         addr_phase  <= 1'b0;
         ack_ok      <= 1'b0;
         stretch_cnt <= '0;
         nack_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else if (accept) begin
         shreg       <= {cmd_addr, 1'b0};
         data_q      <= cmd_data;
         timer       <= '0;
         quarter     <= '0;
         bit_cnt     <= 3'd7;
         addr_phase  <= 1'b1;
         ack_ok      <= 1'b0;
         stretch_cnt <= '0;
         nack_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else if (busy && state != S_DONE) begin
         if (stretched) begin
            timer <= '0;
            if (timeout_hit) begin
               nack_q      <= 1'b1;
               timeout_q   <= 1'b1;
               stretch_cnt <= '0;
            end else begin
               stretch_cnt <= stretch_cnt + 1'b1;
            end
         end else begin
            stretch_cnt <= '0;
            if (q_end) begin
               timer   <= '0;
               quarter <= (state == S_START && quarter == 2'd1) ? 2'd0 : quarter + 2'd1;
               if (state == S_BYTE && quarter == 2'd3) begin
                  shreg   <= {shreg[6:0], 1'b0};
                  bit_cnt <= bit_cnt - 3'd1;
               end
               if (state == S_ACK && quarter == 2'd2) ack_ok <= !sda_i;
               // Address ACK moves on to the data byte; any NACK goes straight to STOP
               if (state == S_ACK && quarter == 2'd3) begin
                  if (addr_phase && ack_ok) begin
                     shreg      <= data_q;
                     bit_cnt    <= 3'd7;
                     addr_phase <= 1'b0;
                  end else if (!ack_ok) begin
                     nack_q <= 1'b1;
                  end
               end
            end else begin
               timer <= timer + 10'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_blctrl_i2c_master.sv
// Bench for blctrl_i2c_master: an I2C slave/bus decoder answers the master and
// records START/byte/STOP events, compared against a transaction-level expectation.
module tb_blctrl_i2c_master;
   localparam int CD       = 4;
   localparam int SL       = 64;
   localparam int EV_START = 256;
   localparam int EV_STOP  = 512;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       cmd_ready, busy, done, nack, timeout;
   logic       scl_i, sda_i, scl_o, sda_o, scl_t, sda_t;

   int n_checks = 0;
   int n_fail   = 0;

   logic       slave_pull = 1'b0;
   logic       prev_scl = 1'b1, prev_sda = 1'b1;
   logic [7:0] sh = 8'd0;
   int         bitn = 0, byte_idx = 0;
   bit         ack_addr_en = 1'b1, ack_data_en = 1'b1;
   bit         hold_forever = 1'b0, stretch_en = 1'b0, stretch_arm = 1'b0;
   int         stretch_cycles = 0, stretch_left = 0;
   int         ev_q[$];
   logic       held;

   logic [6:0] ra;
   logic [7:0] rd;
   bit         raa, rad;
   int         lat, base, seen;
   logic       nk, to;
   logic [7:0] bd[8];
   int         acc_cyc[8], done_cyc[8];
   int         na, nd;
   bit         pend;

   always #5 clk = ~clk;

   blctrl_i2c_master #(.CLK_DIV(CD), .STRETCH_LIMIT(SL)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy), .done(done),
      .nack(nack), .timeout(timeout), .scl_i(scl_i), .sda_i(sda_i),
      .scl_o(scl_o), .sda_o(sda_o), .scl_t(scl_t), .sda_t(sda_t)
   );

   // Open-drain bus with pull-ups: a line is high only if nobody pulls it
   always_comb held = hold_forever || (stretch_arm && stretch_left != 0);
   assign scl_i = scl_t ? ~held : scl_o;
   assign sda_i = sda_t ? ~slave_pull : sda_o;

   always @(posedge clk) begin
      prev_scl <= scl_i;
      prev_sda <= sda_i;
      if (prev_scl && scl_i && prev_sda && !sda_i) begin
         ev_q.push_back(EV_START);
         bitn <= 0; byte_idx <= 0; slave_pull <= 1'b0;
      end else if (prev_scl && scl_i && !prev_sda && sda_i) begin
         ev_q.push_back(EV_STOP);
         slave_pull <= 1'b0;
      end else if (!prev_scl && scl_i) begin
         if (bitn < 8) sh <= {sh[6:0], sda_i};
         bitn <= bitn + 1;
      end else if (prev_scl && !scl_i) begin
         if (bitn == 8) begin
            ev_q.push_back(int'(sh));
            slave_pull <= (byte_idx == 0) ? ack_addr_en : ack_data_en;
         end else if (bitn == 9) begin
            slave_pull <= 1'b0; bitn <= 0; byte_idx <= byte_idx + 1;
         end
         if (stretch_en && byte_idx == 1 && bitn == 4) stretch_arm <= 1'b1;
      end
      if (!stretch_en) begin
         stretch_arm  <= 1'b0;
         stretch_left <= stretch_cycles;
      end else if (stretch_arm && scl_t && stretch_left > 0) begin
         stretch_left <= stretch_left - 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_cmd(input logic [6:0] a, input logic [7:0] d,
                         output int l, output logic nk_o, output logic to_o);
      int n;
      @(negedge clk);
      cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
      check("ready_before_accept", {31'd0, cmd_ready}, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("busy_after_accept", {31'd0, busy}, 1);
      l = 1;
      while (!done && l < 3000) begin @(negedge clk); l++; end
      check("done_seen", {31'd0, done}, 1);
      check("lines_released_at_done", {30'd0, scl_t, sda_t}, 3);
      nk_o = nack; to_o = timeout;
      @(negedge clk);
      check("ready_after_done", {31'd0, cmd_ready}, 1);
      check("busy_after_done", {31'd0, busy}, 0);
   endtask

   task automatic run_check(input logic [6:0] a, input logic [7:0] d,
                            input bit aa, input bit ad, input int stretch);
      int l, b;
      logic k, t;
      int exp_ev[$];
      ack_addr_en = aa; ack_data_en = ad;
      b = ev_q.size();
      do_cmd(a, d, l, k, t);
      check("latency", l, (aa ? 78 : 42) * CD + 1 + stretch);
      check("nack", {31'd0, k}, {31'd0, !(aa && ad)});
      check("timeout", {31'd0, t}, 0);
      exp_ev = {EV_START, int'({a, 1'b0})};
      if (aa) exp_ev.push_back(int'(d));
      exp_ev.push_back(EV_STOP);
      check("event_count", ev_q.size() - b, exp_ev.size());
      foreach (exp_ev[i])
         if (b + i < ev_q.size()) check("bus_event", ev_q[b + i], exp_ev[i]);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
      repeat (3) @(negedge clk);
      check("ready_during_rst", {31'd0, cmd_ready}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_scl_t", {31'd0, scl_t}, 1);
      check("rst_sda_t", {31'd0, sda_t}, 1);
      check("rst_pins_low", {30'd0, scl_o, sda_o}, 0);
      check("rst_ready", {31'd0, cmd_ready}, 1);
      check("rst_flags", {28'd0, busy, done, nack, timeout}, 0);

      run_check(7'h29, 8'hA5, 1'b1, 1'b1, 0);
      run_check(7'h2A, 8'h3C, 1'b0, 1'b1, 0);

      stretch_cycles = 50;
      @(negedge clk);
      stretch_en = 1'b1;
      run_check(7'h2B, 8'h5A, 1'b1, 1'b1, 50);
      stretch_en = 1'b0;

      for (int i = 0; i < 8; i++) begin
         ra  = 7'(41 + $urandom_range(0, 7));
         rd  = 8'($urandom);
         raa = 1'($urandom_range(0, 1));
         rad = 1'($urandom_range(0, 1));
         run_check(ra, rd, raa, rad, 0);
      end

      // Slave never lets SCL go: master must give up after the stretch limit
      hold_forever = 1'b1;
      base = ev_q.size();
      do_cmd(7'h2C, 8'h11, lat, nk, to);
      check("timeout_latency", lat, SL + 1);
      check("timeout_nack", {31'd0, nk}, 1);
      check("timeout_flag", {31'd0, to}, 1);
      check("timeout_no_events", ev_q.size() - base, 0);
      hold_forever = 1'b0;
      repeat (2) @(negedge clk);

      ack_addr_en = 1'b1; ack_data_en = 1'b1;
      @(negedge clk);
      cmd_addr = 7'h2D; cmd_data = 8'hC3; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (190) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_lines", {30'd0, scl_t, sda_t}, 3);
      check("midrst_busy", {31'd0, busy}, 0);
      check("midrst_ready", {31'd0, cmd_ready}, 0);
      rst = 1'b0;
      seen = 0;
      repeat (400) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      check("midrst_no_done", seen, 0);
      check("midrst_nack", {31'd0, nack}, 0);
      run_check(7'h2E, 8'h77, 1'b1, 1'b1, 0);

      // Eight back-to-back commands with cmd_valid held high
      base = ev_q.size();
      foreach (bd[i]) bd[i] = 8'($urandom);
      na = 0; nd = 0; pend = 1'b0;
      @(negedge clk);
      cmd_addr = 7'h29; cmd_data = bd[0]; cmd_valid = 1'b1;
      for (int c = 0; c < 8 * (78 * CD + 10) && nd < 8; c++) begin
         if (pend) begin
            pend = 1'b0;
            if (na < 8) begin cmd_addr = 7'(41 + na); cmd_data = bd[na]; end
            else cmd_valid = 1'b0;
         end
         if (cmd_valid && cmd_ready && na < 8) begin acc_cyc[na] = c; na++; pend = 1'b1; end
         if (done) begin done_cyc[nd] = c; nd++; end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      check("b2b_accepts", na, 8);
      check("b2b_dones", nd, 8);
      for (int i = 0; i < 8; i++) begin
         check("b2b_latency", done_cyc[i] - acc_cyc[i], 78 * CD + 1);
         if (i > 0) check("b2b_idle_gap", acc_cyc[i] - done_cyc[i-1], 1);
      end
      check("b2b_event_count", ev_q.size() - base, 32);
      for (int i = 0; i < 8; i++) begin
         if (base + 4 * i + 3 < ev_q.size()) begin
            check("b2b_start", ev_q[base + 4 * i], EV_START);
            check("b2b_addr", ev_q[base + 4 * i + 1], (41 + i) * 2);
            check("b2b_data", ev_q[base + 4 * i + 2], int'(bd[i]));
            check("b2b_stop", ev_q[base + 4 * i + 3], EV_STOP);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
